intr_arbiter: RTL and testbench
===============================

# intr_arbiter

Interrupt request front end feeding CP0's `interruptSignal` input in the pipelined MIPS core. Synchronises three external interrupt lines and accepts software-set requests. Latches rising edges as pending requests and tracks nesting with an in-service stack that CP0 updates through accept/ERET pulses. Presents the highest deliverable priority level (0–3) so CP0 can compare it against its current ring.

## Interface
- `LOST_W`, default 8: width of the saturating lost-request counter.
- `clk  in  1`: core clock.
- `rst  in  1`: reset; synchronous, active-high.
- `irq_in  in  3`: external lines, asynchronous to `clk`; bit i is source i, priority level i+1.
- `sw_set  in  3`: one-cycle software request pulses, already in the `clk` domain.
- `int_en  in  1`: global enable; CP0 status[15:8]==8'hff, computed upstream.
- `int_ack  in  1`: one-cycle pulse when CP0 takes an interrupt; the level taken is the current `interruptSignal`.
- `exc_taken  in  1`: one-cycle pulse when CP0 takes an internal exception.
- `eret  in  1`: one-cycle pulse when CP0 executes ERET.
- `lost_clr  in  1`: clears `lost_cnt`.
- `interruptSignal  out  3`: deliverable level 0–3; combinational from registers.
- `pending  out  3`: pending request bits.
- `in_service  out  3`: in-service bits.
- `lost_cnt  out  LOST_W`: saturating count of requests that arrived while already pending.

## Operation
- Reset values:
  - `pending`=0, `in_service`=0, exception flag=0, `lost_cnt`=0.
  - All synchroniser and edge flops are 0, so `interruptSignal`=0.
- Request capture:
  - `req[i]` = rising edge of synchronised `irq_in[i]`, OR `sw_set[i]`.
  - `req[i]` sets `pending[i]`.
  - If `pending[i]` is already 1 and not being cleared this cycle, `lost_cnt` increments once per cycle, however many sources collide. It saturates at 2^LOST_W−1.
  - `lost_clr` has priority over increment.
- Delivery:
  - top_is = index+1 of the highest set `in_service` bit, 0 if none.
  - cand = index+1 of the highest set `pending` bit, 0 if none.
  - `interruptSignal` = cand when `int_en`=1 and cand > top_is; otherwise 0.
  - Pending requests accumulate while `int_en`=0.
- `int_ack` with `interruptSignal`=L≠0: clear `pending[L−1]` and set `in_service[L−1]`. `int_ack` with `interruptSignal`=0 is ignored.
- `exc_taken`: sets the exception flag (single level; a repeat while set is a no-op).
- `eret`:
  - Exception flag set: clear the flag; `in_service` is untouched.
  - Flag clear: clear the highest set `in_service` bit.
  - Flag clear and `in_service` empty: no-op.
- Simultaneous events, applied in this order:
  - `eret` then `int_ack`, both evaluated against start-of-cycle state.
  - `req[i]` in the same cycle as an ack of source i leaves `pending[i]`=1 and counts nothing lost.
  - `exc_taken` together with `eret` (flag clear): pop `in_service` and set the flag.
- `rst` mid-operation discards all pending, in-service and flag state on that edge.

## Timing
- `INTR_SYNC_EN` defined:
  - `irq_in` rises before posedge k; `pending` is set at posedge k+2.
  - `interruptSignal` is valid after k+2.
- `INTR_SYNC_EN` undefined: `pending` is set at posedge k+1.
- `sw_set` at posedge k sets `pending` at k.
- Ack, ERET and exception-pulse updates take effect at the edge that samples them. `interruptSignal` reflects them in the next cycle.
- A line held high produces one request only; it must fall and rise again to request again.

## Configuration
- `INTR_SYNC_EN` defined:
  - Two-flop synchroniser per line, then an edge-history flop.
  - Edge detection on the second synchroniser flop.
- Undefined:
  - Single input register feeding the edge-history flop.
  - For lines already synchronous to `clk`.
- Both builds keep the same ports.

## Structure
- Package `intr_pkg`:
  - `NUM_SRC`=3.
  - Level constants `LVL_NONE`=0 through `LVL_3`=3, aligned with CP0 ring values.
  - Priority-encode function returning index+1.
- Sub-module `intr_sync`, one instance per source:
  - Contains the synchroniser (macro-controlled) and the rising-edge detector.
  - Outputs a one-cycle `rise` pulse.

## Test plan
- Reset, then `irq_in`=3'b001 held (sync build), `int_en`=1 -> `pending`=3'b001 at k+2, `interruptSignal`=1; `irq_in` stays high -> no second request.
- `sw_set`=3'b100, ack -> `in_service`=3'b100; then `sw_set`=3'b010 -> `interruptSignal`=0 (2 ≤ 3); `eret` -> `interruptSignal`=2.
- Level-1 in service, `sw_set`=3'b010 -> `interruptSignal`=2; ack -> `in_service`=3'b011; `eret` twice -> `in_service`=3'b001, then 0.
- `in_service`=3'b001, `exc_taken`, then `eret` -> flag cleared, `in_service` still 3'b001; second `eret` -> 0.
- `sw_set`=3'b001 on 300 consecutive cycles without ack -> `lost_cnt`=255 (saturated); `lost_clr` -> 0.
- `int_en`=0 with pending 3'b101 -> `interruptSignal`=0; `int_en`=1 -> 3; `rst` asserted mid-stream -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/intr_pkg.sv
// intr_pkg: shared source count, CP0-aligned level constants and priority helpers
package intr_pkg;
  localparam int NUM_SRC = 3;
  localparam logic [2:0] LVL_NONE = 3'd0;
  localparam logic [2:0] LVL_1 = 3'd1;
  localparam logic [2:0] LVL_2 = 3'd2;
  localparam logic [2:0] LVL_3 = 3'd3;
  function automatic logic [2:0] penc(input logic [NUM_SRC-1:0] v);
    penc = LVL_NONE;
    for (int k = 0; k < NUM_SRC; k++)
      if (v[k]) penc = 3'(k + 1);
  endfunction
  function automatic logic [NUM_SRC-1:0] lvl_bit(input logic [2:0] l);
    lvl_bit = '0;
    for (int k = 0; k < NUM_SRC; k++)
      lvl_bit[k] = (l == 3'(k + 1));
  endfunction
endpackage

// File: rtl/intr_sync.sv
// intr_sync: per-line input capture and rising-edge pulse; INTR_SYNC_EN selects a
// two-flop synchroniser for asynchronous lines, otherwise a single input register.
module intr_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  output logic rise
);
`ifdef INTR_SYNC_EN
  logic s1, s2, hist;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      hist <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      hist <= s2;
    end
  assign rise = s2 & ~hist;
`else
  logic r, hist;
  always_ff @(posedge clk)
    if (rst) begin
      r <= 1'b0;
      hist <= 1'b0;
    end else begin
      r <= irq;
      hist <= r;
    end
  assign rise = r & ~hist;
`endif
endmodule

// File: rtl/intr_arbiter.sv
// intr_arbiter: pending/in-service interrupt tracking feeding CP0's interruptSignal;
// INTR_SYNC_EN chooses the synchronised input path in intr_sync.
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int LOST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        irq_in,
  input  logic [2:0]        sw_set,
  input  logic              int_en,
  input  logic              int_ack,
  input  logic              exc_taken,
  input  logic              eret,
  input  logic              lost_clr,
  output logic [2:0]        interruptSignal,
  output logic [2:0]        pending,
  output logic [2:0]        in_service,
  output logic [LOST_W-1:0] lost_cnt
);
  logic [NUM_SRC-1:0] rise, req, ack_clr, eret_clr, lost_hit;
  logic [2:0] top_is, cand;
  logic exc_flag;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    intr_sync u_sync (.clk(clk), .rst(rst), .irq(irq_in[i]), .rise(rise[i]));
  end
  // eret and ack both look at start-of-cycle state; ack level always exceeds the popped top
  always_comb begin
    top_is = penc(in_service);
    cand = penc(pending);
    interruptSignal = (int_en && cand > top_is) ? cand : LVL_NONE;
    req = rise | sw_set;
    ack_clr = int_ack ? lvl_bit(interruptSignal) : '0;
    eret_clr = (eret && !exc_flag) ? lvl_bit(top_is) : '0;
    lost_hit = req & pending & ~ack_clr;
  end
  always_ff @(posedge clk)
    if (rst) begin
      pending <= '0;
      in_service <= '0;
      exc_flag <= 1'b0;
      lost_cnt <= '0;
    end else begin
      pending <= (pending & ~ack_clr) | req;
      in_service <= (in_service & ~eret_clr) | ack_clr;
      exc_flag <= (exc_flag & ~eret) | exc_taken;
      lost_cnt <= lost_clr ? '0 : (|lost_hit && lost_cnt != '1) ? lost_cnt + LOST_W'(1) : lost_cnt;
    end
endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter: directed plan scenarios then random traffic against a queue-based reference model
module tb_intr_arbiter;
  localparam int LOST_W = 8;
`ifdef INTR_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  logic clk = 1'b0;
  logic rst, int_en, int_ack, exc_taken, eret, lost_clr;
  logic [2:0] irq_in, sw_set, interruptSignal, pending, in_service;
  logic [LOST_W-1:0] lost_cnt;
  int vectors = 0, errs = 0;
  logic [2:0] m_pend;
  int is_q[$];
  bit m_flag;
  int m_lost;
  logic [2:0] hist[$];

  always #5 clk = ~clk;

  intr_arbiter #(.LOST_W(LOST_W)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .sw_set(sw_set), .int_en(int_en),
    .int_ack(int_ack), .exc_taken(exc_taken), .eret(eret), .lost_clr(lost_clr),
    .interruptSignal(interruptSignal), .pending(pending), .in_service(in_service),
    .lost_cnt(lost_cnt)
  );

  function automatic int hi(input logic [2:0] v);
    for (int i = 2; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic int exp_lvl();
    int top, c;
    top = is_q.size() ? is_q[$] : 0;
    c = hi(m_pend);
    return (int_en && c > top) ? c : 0;
  endfunction

  function automatic logic [2:0] is_bits();
    logic [2:0] b;
    b = '0;
    foreach (is_q[i]) b[is_q[i]-1] = 1'b1;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [2:0] rise, req;
    int lvl;
    bit hit;
    if (rst) begin
      m_pend = '0;
      is_q.delete();
      m_flag = 0;
      m_lost = 0;
      hist.delete();
      repeat (D + 1) hist.push_back(3'b000);
      return;
    end
    lvl = exp_lvl();
    rise = hist[D-1] & ~hist[D];
    hist.push_front(irq_in);
    void'(hist.pop_back());
    req = rise | sw_set;
    hit = 0;
    for (int i = 0; i < 3; i++)
      if (req[i] && m_pend[i] && !(int_ack && lvl == i + 1)) hit = 1;
    if (eret) begin
      if (m_flag) m_flag = 0;
      else if (is_q.size() > 0) void'(is_q.pop_back());
    end
    if (exc_taken) m_flag = 1;
    if (int_ack && lvl != 0) begin
      m_pend[lvl-1] = 1'b0;
      is_q.push_back(lvl);
    end
    m_pend |= req;
    if (lost_clr) m_lost = 0;
    else if (hit && m_lost < (1 << LOST_W) - 1) m_lost++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("pending", 32'(pending), 32'(m_pend));
    chk("in_service", 32'(in_service), 32'(is_bits()));
    chk("lost_cnt", 32'(lost_cnt), 32'(m_lost));
    chk("interruptSignal", 32'(interruptSignal), 32'(exp_lvl()));
  endtask

  task automatic cyc(input logic [2:0] ir, input logic [2:0] sw, input logic en, input logic ack,
                     input logic exc, input logic er, input logic lc, input logic r);
    irq_in = ir; sw_set = sw; int_en = en; int_ack = ack;
    exc_taken = exc; eret = er; lost_clr = lc; rst = r;
    tick();
  endtask

  initial begin
    cyc(3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    cyc(3'b000, 3'b000, 0, 0, 0, 0, 0, 1);
    chk("rst_int", 32'(interruptSignal), 0);
    chk("rst_pend", 32'(pending), 0);
    // external line held high: one request, acked, then no re-request
    repeat (4) cyc(3'b001, 3'b000, 1, 0, 0, 0, 0, 0);
    chk("irq_pend", 32'(pending), 32'b001);
    chk("irq_lvl", 32'(interruptSignal), 1);
    cyc(3'b001, 3'b000, 1, 1, 0, 0, 0, 0);
    repeat (4) cyc(3'b001, 3'b000, 1, 0, 0, 0, 0, 0);
    chk("irq_held", 32'(pending), 0);
    cyc(3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
    chk("irq_eret", 32'(in_service), 0);
    // level 3 in service masks level 2
    cyc(3'b000, 3'b100, 1, 0, 0, 0, 0, 0);
    cyc(3'b000, 3'b000, 1, 1, 0, 0, 0, 0);
    chk("is_100", 32'(in_service), 32'b100);
    cyc(3'b000, 3'b010, 1, 0, 0, 0, 0, 0);
    chk("masked", 32'(interruptSignal), 0);
    cyc(3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
    chk("unmasked", 32'(interruptSignal), 2);
    cyc(3'b000, 3'b000, 1, 1, 0, 0, 0, 0);
    cyc(3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
    // nesting: level 1 then level 2
    cyc(3'b000, 3'b001, 1, 0, 0, 0, 0, 0);
    cyc(3'b000, 3'b000, 1, 1, 0, 0, 0, 0);
    cyc(3'b000, 3'b010, 1, 0, 0, 0, 0, 0);
    chk("nest_lvl", 32'(interruptSignal), 2);
    cyc(3'b000, 3'b000, 1, 1, 0, 0, 0, 0);
    chk("nest_is", 32'(in_service), 32'b011);
    cyc(3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
    chk("nest_pop1", 32'(in_service), 32'b001);
    // exception nests over interrupt level 1
    cyc(3'b000, 3'b000, 1, 0, 1, 0, 0, 0);
    cyc(3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
    chk("exc_eret", 32'(in_service), 32'b001);
    cyc(3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
    chk("nest_pop2", 32'(in_service), 0);
    // lost counter saturation
    repeat (300) cyc(3'b000, 3'b001, 0, 0, 0, 0, 0, 0);
    chk("lost_sat", 32'(lost_cnt), 255);
    cyc(3'b000, 3'b000, 0, 0, 0, 0, 1, 0);
    chk("lost_clr", 32'(lost_cnt), 0);
    cyc(3'b000, 3'b100, 0, 0, 0, 0, 0, 0);
    chk("en_off", 32'(interruptSignal), 0);
    cyc(3'b000, 3'b000, 1, 0, 0, 0, 0, 0);
    chk("en_on", 32'(interruptSignal), 3);
    cyc(3'b000, 3'b000, 1, 1, 0, 0, 0, 0);
    cyc(3'b000, 3'b000, 1, 0, 0, 0, 0, 1);
    chk("mid_rst_is", 32'(in_service), 0);
    chk("mid_rst_pend", 32'(pending), 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] ir;
      ir = irq_in;
      if ($urandom_range(0, 3) == 0) ir[$urandom_range(0, 2)] ^= 1'b1;
      cyc(ir, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000,
          $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 5) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
